// File: rtl/note_source_sched_pkg.sv
// ============================================================================
// note_source_sched_pkg
//   Shared note codes, FSM state encodings and MODE_SEL encodings.
//   Revision: 1.0
// ============================================================================
`default_nettype none

package note_source_sched_pkg;

  localparam logic [3:0] NOTE_NONE = 4'h8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_MANUAL = 3'd1;
  localparam logic [2:0] ST_AUTO   = 3'd2;
  localparam logic [2:0] ST_RECORD = 3'd3;
  localparam logic [2:0] ST_PLAY   = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_RECORD = 2'b10;
  localparam logic [1:0] MODE_PLAY   = 2'b11;

  function automatic logic [2:0] mode_state(input logic [1:0] mode);
    logic [2:0] st;
    case (mode)
      MODE_MANUAL: st = ST_MANUAL;
      MODE_AUTO:   st = ST_AUTO;
      MODE_RECORD: st = ST_RECORD;
      default:     st = ST_PLAY;
    endcase
    return st;
  endfunction

endpackage

`default_nettype wire

// File: rtl/note_rec_mem.sv
// ============================================================================
// note_rec_mem
//   Single-port synchronous RAM holding the recorded take; registered read.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module note_rec_mem #(
  parameter int DEPTH = 64,
  parameter int AW    = 6,
  parameter int W     = 4
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [W-1:0]  i_wdata,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/note_source_sched.sv
// ============================================================================
// note_source_sched
//   Selects the note source (keypad, song sequencer or recorded take) for the
//   tone generator. Optional macro PLAYBACK_LOOP_EN makes playback loop forever.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module note_source_sched
  import note_source_sched_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int AW     = 6,
  parameter int NOTE_W = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              QBEAT_TICK,
  input  logic [1:0]        MODE_SEL,
  input  logic [NOTE_W-1:0] KEY_NOTE,
  input  logic [NOTE_W-1:0] AUTO_NOTE,
  output logic              AUTO_RESTART,
  output logic [NOTE_W-1:0] note,
  output logic [2:0]        state,
  output logic [AW:0]       rec_len,
  output logic              rec_full
);

  localparam logic [AW:0]       c_DEPTH = (AW+1)'(DEPTH);
  localparam logic [NOTE_W-1:0] c_NONE  = NOTE_W'(NOTE_NONE);

  logic [1:0]        r_mode_q;
  logic [2:0]        r_state, w_state_n;
  logic [NOTE_W-1:0] r_note, w_note_n;
  logic              r_restart;
  logic [AW:0]       r_wr_ptr, w_wr_ptr_n;
  logic [AW:0]       r_rd_ptr, w_rd_ptr_n;
  logic [AW:0]       r_rec_len, w_rec_len_n;
  logic              r_rec_full, w_rec_full_n;
  logic              w_we;
  logic [AW-1:0]     w_mem_addr;
  logic [NOTE_W-1:0] w_rdata;
  logic              w_mode_chg, w_tick, w_take_end;
  logic [AW:0]       w_rd_next, w_rd_adv, w_len_inc;

  // A mode change takes priority over a beat tick in the same cycle.
  assign w_mode_chg = (MODE_SEL != r_mode_q);
  assign w_tick     = QBEAT_TICK & ~w_mode_chg;
  assign w_rd_next  = r_rd_ptr + 1'b1;
  assign w_len_inc  = r_rec_len + 1'b1;

`ifdef PLAYBACK_LOOP_EN
  // Wrap as the last entry is consumed so entry 0 is already prefetched.
  assign w_rd_adv   = (w_rd_next == r_rec_len) ? '0 : w_rd_next;
  assign w_take_end = 1'b0;
`else
  assign w_rd_adv   = w_rd_next;
  assign w_take_end = (r_rd_ptr == r_rec_len);
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    if (w_mode_chg) begin
      w_state_n = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: w_state_n = mode_state(r_mode_q);
        ST_PLAY: begin
          if ((r_rec_len == '0) || (w_tick && w_take_end)) begin
            w_state_n = ST_DONE;
          end
        end
        default: w_state_n = r_state;
      endcase
    end
  end

  always_comb begin
    w_note_n     = r_note;
    w_we         = 1'b0;
    w_wr_ptr_n   = r_wr_ptr;
    w_rd_ptr_n   = r_rd_ptr;
    w_rec_len_n  = r_rec_len;
    w_rec_full_n = r_rec_full;
    if (w_mode_chg) begin
      w_note_n = c_NONE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_note_n = c_NONE;
          if (r_mode_q == MODE_RECORD) begin
            w_wr_ptr_n   = '0;
            w_rec_len_n  = '0;
            w_rec_full_n = 1'b0;
          end
          if (r_mode_q == MODE_PLAY) begin
            w_rd_ptr_n = '0;
          end
        end
        ST_MANUAL: w_note_n = KEY_NOTE;
        ST_AUTO:   w_note_n = AUTO_NOTE;
        ST_RECORD: begin
          w_note_n = KEY_NOTE;
          if (w_tick && !r_rec_full) begin
            w_we         = 1'b1;
            w_wr_ptr_n   = r_wr_ptr + 1'b1;
            w_rec_len_n  = w_len_inc;
            w_rec_full_n = (w_len_inc == c_DEPTH);
          end
        end
        ST_PLAY: begin
          if ((r_rec_len == '0) || (w_tick && w_take_end)) begin
            w_note_n = c_NONE;
          end else if (w_tick) begin
            w_note_n   = w_rdata;
            w_rd_ptr_n = w_rd_adv;
          end
        end
        default: w_note_n = c_NONE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_mode_q   <= MODE_MANUAL;
      r_note     <= c_NONE;
      r_restart  <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_rec_len  <= '0;
      r_rec_full <= 1'b0;
    end else begin
      r_mode_q   <= MODE_SEL;
      r_note     <= w_note_n;
      r_restart  <= (w_state_n == ST_AUTO) && (r_state != ST_AUTO);
      r_wr_ptr   <= w_wr_ptr_n;
      r_rd_ptr   <= w_rd_ptr_n;
      r_rec_len  <= w_rec_len_n;
      r_rec_full <= w_rec_full_n;
    end
  end

  // Read address follows the next pointer so data is ready one cycle ahead.
  assign w_mem_addr = w_we ? r_wr_ptr[AW-1:0] : w_rd_ptr_n[AW-1:0];

  note_rec_mem #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (NOTE_W)
  ) u_mem (
    .i_clk   (CLK),
    .i_we    (w_we),
    .i_addr  (w_mem_addr),
    .i_wdata (KEY_NOTE),
    .o_rdata (w_rdata)
  );

  assign AUTO_RESTART = r_restart;
  assign note         = r_note;
  assign state        = r_state;
  assign rec_len      = r_rec_len;
  assign rec_full     = r_rec_full;

endmodule

`default_nettype wire
